// File: rtl/sync_fifo_param_pkg.sv
// Shared helpers for the parametrised synchronous FIFO: count width and
// parameter legality rules.
package fifo_pkg;

    function automatic int cnt_w(int depth);
        return $clog2(depth) + 1;
    endfunction

    // Depth must be a power of two so the pointers can simply wrap.
    function automatic bit params_ok(int depth, int af_level, int ae_level);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (af_level >= 1) && (af_level <= depth) &&
               (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_param_mem.sv
// FIFO storage: synchronous write port and a registered read port whose
// output register resets to zero and holds when no read is issued.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A read and write to the same slot return the old contents, which is
    // what the full-FIFO simultaneous read/write case relies on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with threshold flags, synchronous flush and
// sticky overflow/underflow flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      wr,
    input  logic [WIDTH-1:0]          data_in,
    input  logic                      rd,
    output logic [WIDTH-1:0]          data_out,
    output logic                      data_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   fifo_cnt,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    if (!params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("sync_fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;
    logic          wr_do;
    logic          rd_do;

    assign full         = (fifo_cnt == CW'(DEPTH));
    assign empty        = (fifo_cnt == '0);
    assign almost_full  = (fifo_cnt >= CW'(AF_LEVEL));
    assign almost_empty = (fifo_cnt <= CW'(AE_LEVEL));

    assign wr_ok = wr && (!full || rd);
    assign rd_ok = rd && !empty;
    // Flush swallows any request issued in the same cycle.
    assign wr_do = wr_ok && !flush;
    assign rd_do = rd_ok && !flush;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_do),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (rd_do),
        .raddr (rd_ptr),
        .rdata (data_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            data_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_ok;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_ok && !rd_ok) begin
                fifo_cnt <= fifo_cnt + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                fifo_cnt <= fifo_cnt - CW'(1);
            end
        end
    end

    // A new error in the same cycle as clr_err wins, keeping the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  && !clr_err) || (!flush && wr && !wr_ok);
            underflow <= (underflow && !clr_err) || (!flush && rd && !rd_ok);
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed plus randomized bench for sync_fifo_param, checked every cycle
// against a queue-based model of the FIFO behaviour.
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             wr;
    logic [WIDTH-1:0] data_in;
    logic             rd;
    logic             clr_err;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [3:0]       fifo_cnt;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int fails  = 0;

    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] m_dout;
    logic             m_dv;
    logic             m_ov;
    logic             m_uf;

    sync_fifo_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr           (wr),
        .data_in      (data_in),
        .rd           (rd),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_cnt     (fifo_cnt),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_dv   = 1'b0;
        m_ov   = 1'b0;
        m_uf   = 1'b0;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_output();
        int n;
        n = q.size();
        checks++;
        assert (data_out === m_dout) else begin
            fails++;
            $error("[TB] FAIL data_out: observed %h expected %h at %0t", data_out, m_dout, $time);
        end
        checks++;
        assert (fifo_cnt === 4'(n)) else begin
            fails++;
            $error("[TB] FAIL fifo_cnt: observed %0d expected %0d at %0t", fifo_cnt, n, $time);
        end
        check_bit("data_valid", data_valid, m_dv);
        check_bit("full", full, n == DEPTH);
        check_bit("empty", empty, n == 0);
        check_bit("almost_full", almost_full, n >= AF);
        check_bit("almost_empty", almost_empty, n <= AE);
        check_bit("overflow", overflow, m_ov);
        check_bit("underflow", underflow, m_uf);
    endtask

    // One clock of stimulus; the model applies the FIFO rules at the same edge.
    task automatic apply_stimulus(input logic w, input logic [WIDTH-1:0] d,
                                  input logic r, input logic f, input logic c);
        logic wok;
        logic rok;
        wr      = w;
        data_in = d;
        rd      = r;
        flush   = f;
        clr_err = c;
        @(posedge clk);
        wok  = w && ((q.size() != DEPTH) || r);
        rok  = r && (q.size() != 0);
        m_ov = (m_ov && !c) || (!f && w && !wok);
        m_uf = (m_uf && !c) || (!f && r && !rok);
        if (f) begin
            q.delete();
            m_dv = 1'b0;
        end else begin
            m_dv = rok;
            if (rok) m_dout = q.pop_front();
            if (wok) q.push_back(d);
        end
        #1;
        check_output();
    endtask

    initial begin
        rst_n = 1'b0; flush = 0; wr = 0; rd = 0; clr_err = 0; data_in = '0;
        model_reset();
        #12;
        check_output();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill 0x01..0x08, then drain in order.
        for (int i = 1; i <= DEPTH; i++) apply_stimulus(1, 8'(i), 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) apply_stimulus(0, 8'h00, 1, 0, 0);
        apply_stimulus(0, 8'h00, 0, 0, 0);

        // Full with simultaneous read/write, then drain to see 0xAA last.
        for (int i = 1; i <= DEPTH; i++) apply_stimulus(1, 8'(8'h10 + i), 0, 0, 0);
        apply_stimulus(1, 8'hAA, 1, 0, 0);
        for (int i = 0; i < DEPTH; i++) apply_stimulus(0, 8'h00, 1, 0, 0);

        // Overflow when full, stickiness, then clear.
        for (int i = 1; i <= DEPTH; i++) apply_stimulus(1, 8'(8'h20 + i), 0, 0, 0);
        apply_stimulus(1, 8'hEE, 0, 0, 0);
        apply_stimulus(0, 8'h00, 0, 0, 0);
        apply_stimulus(0, 8'h00, 0, 0, 1);
        apply_stimulus(1, 8'hEF, 0, 0, 1);
        apply_stimulus(0, 8'h00, 0, 0, 1);

        // Empty with simultaneous read/write: no bypass, underflow.
        apply_stimulus(0, 8'h00, 0, 1, 0);
        apply_stimulus(1, 8'h55, 1, 0, 0);
        apply_stimulus(0, 8'h00, 1, 0, 0);
        apply_stimulus(0, 8'h00, 0, 0, 1);

        // Pointer wrap, then flush with a write pending.
        for (int i = 0; i < 13; i++) apply_stimulus(1, 8'(8'h60 + i), (i % 2) == 1, 0, 0);
        apply_stimulus(1, 8'h77, 1, 1, 0);
        apply_stimulus(0, 8'h00, 1, 0, 0);
        apply_stimulus(0, 8'h00, 0, 0, 1);

        // Randomized traffic with varying write/read bias.
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = ((i / 50) % 2 == 0) ? 70 : 30;
            apply_stimulus($urandom_range(0, 99) < wp, 8'($urandom),
                           $urandom_range(0, 99) < (100 - wp),
                           $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0);
        end

        // Asynchronous reset mid-stream, observed before any clock edge.
        for (int i = 0; i < 5; i++) apply_stimulus(1, 8'($urandom), 0, 0, 0);
        apply_stimulus(1, 8'hF0, 1, 0, 0);
        wr = 0; rd = 0; flush = 0; clr_err = 0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_output();
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(1, 8'h3C, 0, 0, 0);
        apply_stimulus(0, 8'h00, 1, 0, 0);
        apply_stimulus(0, 8'h00, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
